// File: rtl/fft_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// fft_frame_arbiter_if
// Bundles the two antenna sample streams and the FFT-side sample stream used
// by fft_frame_arbiter.
//   s0_* / s1_* : per-antenna AXIS input (tvalid, tlast, re/im data, tready)
//   m_*         : AXIS output to the FFT wrapper (adds tid = source channel)
// Modports:
//   slave  : the arbiter (consumes s0/s1, produces m)
//   master : the surrounding logic (produces s0/s1, consumes m)
// ---------------------------------------------------------------------------
interface fft_frame_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             s0_axis_tvalid;
  logic             s0_axis_tlast;
  logic [WIDTH-1:0] s0_re_axis_tdata;
  logic [WIDTH-1:0] s0_im_axis_tdata;
  logic             s0_axis_tready;

  logic             s1_axis_tvalid;
  logic             s1_axis_tlast;
  logic [WIDTH-1:0] s1_re_axis_tdata;
  logic [WIDTH-1:0] s1_im_axis_tdata;
  logic             s1_axis_tready;

  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [WIDTH-1:0] m_re_axis_tdata;
  logic [WIDTH-1:0] m_im_axis_tdata;
  logic             m_axis_tid;
  logic             m_axis_tready;

  modport slave (
    input  s0_axis_tvalid, s0_axis_tlast, s0_re_axis_tdata, s0_im_axis_tdata,
    output s0_axis_tready,
    input  s1_axis_tvalid, s1_axis_tlast, s1_re_axis_tdata, s1_im_axis_tdata,
    output s1_axis_tready,
    output m_axis_tvalid, m_axis_tlast, m_re_axis_tdata, m_im_axis_tdata, m_axis_tid,
    input  m_axis_tready
  );

  modport master (
    output s0_axis_tvalid, s0_axis_tlast, s0_re_axis_tdata, s0_im_axis_tdata,
    input  s0_axis_tready,
    output s1_axis_tvalid, s1_axis_tlast, s1_re_axis_tdata, s1_im_axis_tdata,
    input  s1_axis_tready,
    input  m_axis_tvalid, m_axis_tlast, m_re_axis_tdata, m_im_axis_tdata, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/fft_frame_arbiter.sv
// ---------------------------------------------------------------------------
// fft_frame_arbiter
// Shares one FFT wrapper between two antenna streams. Each input symbol is
// CP_LEN + FFT_LEN samples ending in tlast. One channel is granted per whole
// symbol (round-robin), the cyclic prefix is dropped and exactly FFT_LEN
// samples are forwarded with tlast on the last and tid = channel. Short
// symbols are zero-padded, long symbols are drained.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus              : stream bundle (slave modport)
//   err_clr_in       : clears sticky error flags (a same-cycle set wins)
//   err_short_out    : sticky, a symbol ended early
//   err_long_out     : sticky, a symbol ran past CP_LEN + FFT_LEN samples
//   frame_cnt_out    : frames emitted (beats with tlast), wraps
// ---------------------------------------------------------------------------
module fft_frame_arbiter #(
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16,
  parameter int WIDTH   = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  fft_frame_arbiter_if.slave  bus,
  input  logic                err_clr_in,
  output logic                err_short_out,
  output logic                err_long_out,
  output logic [15:0]         frame_cnt_out
);

  localparam int IW = $clog2((FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN) + 1;

  typedef enum logic [2:0] {IDLE, CP, PASS, PAD, DRAIN} state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic [IW-1:0]    r_idx;
  logic             r_m_vld;
  logic             r_m_last;
  logic             r_m_tid;
  logic [WIDTH-1:0] r_m_re;
  logic [WIDTH-1:0] r_m_im;
  logic             r_err_short;
  logic             r_err_long;
  logic [15:0]      r_frame_cnt;

  logic             w_vld;
  logic             w_last;
  logic [WIDTH-1:0] w_re;
  logic [WIDTH-1:0] w_im;
  logic             w_out_free;
  logic             w_rdy;
  logic             w_acc;
  logic             w_idx_last;
  logic             w_cp_last;
  logic             w_set_short;
  logic             w_set_long;
  logic             w_grant_nxt;

  // Granted channel view
  assign w_vld  = r_grant ? bus.s1_axis_tvalid   : bus.s0_axis_tvalid;
  assign w_last = r_grant ? bus.s1_axis_tlast    : bus.s0_axis_tlast;
  assign w_re   = r_grant ? bus.s1_re_axis_tdata : bus.s0_re_axis_tdata;
  assign w_im   = r_grant ? bus.s1_im_axis_tdata : bus.s0_im_axis_tdata;

  // Single output register: free when empty or being taken this cycle
  assign w_out_free = !r_m_vld || bus.m_axis_tready;

  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      CP, DRAIN: w_rdy = 1'b1;
      PASS:      w_rdy = w_out_free;
      default:   w_rdy = 1'b0;
    endcase
  end

  assign w_acc      = w_rdy && w_vld;
  assign w_idx_last = (r_idx == IW'(FFT_LEN - 1));
  assign w_cp_last  = (r_idx == IW'(CP_LEN - 1));

  // Ungranted channel is never ready, so its stream just stalls upstream
  assign bus.s0_axis_tready = w_rdy && !r_grant;
  assign bus.s1_axis_tready = w_rdy &&  r_grant;

  // Both requesting: alternate away from the previous winner
  assign w_grant_nxt = (bus.s0_axis_tvalid && bus.s1_axis_tvalid) ? !r_last_grant
                                                                   : bus.s1_axis_tvalid;

  assign w_set_short = w_acc && w_last &&
                       ((r_state == CP) || ((r_state == PASS) && !w_idx_last));
  assign w_set_long  = w_acc && !w_last && (r_state == PASS) && w_idx_last;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_idx        <= '0;
      r_m_vld      <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_tid      <= 1'b0;
      r_m_re       <= '0;
      r_m_im       <= '0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_err_short <= w_set_short || (r_err_short && !err_clr_in);
      r_err_long  <= w_set_long  || (r_err_long  && !err_clr_in);

      if (r_m_vld && bus.m_axis_tready) begin
        r_m_vld <= 1'b0;  // overridden below when a new beat is loaded
        if (r_m_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (bus.s0_axis_tvalid || bus.s1_axis_tvalid) begin
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_grant_nxt;
            r_idx        <= '0;
            r_state      <= CP;
          end
        end
        CP: begin
          if (w_acc) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= PAD;
            end else if (w_cp_last) begin
              r_idx   <= '0;
              r_state <= PASS;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        PASS: begin
          if (w_acc) begin
            r_m_vld  <= 1'b1;
            r_m_last <= w_idx_last;
            r_m_tid  <= r_grant;
            r_m_re   <= w_re;
            r_m_im   <= w_im;
            r_idx    <= r_idx + IW'(1);
            if (w_idx_last)  r_state <= w_last ? IDLE : DRAIN;
            else if (w_last) r_state <= PAD;
          end
        end
        PAD: begin
          if (w_out_free) begin
            r_m_vld  <= 1'b1;
            r_m_last <= w_idx_last;
            r_m_tid  <= r_grant;
            r_m_re   <= '0;
            r_m_im   <= '0;
            r_idx    <= r_idx + IW'(1);
            if (w_idx_last) r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_acc && w_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_axis_tvalid   = r_m_vld;
  assign bus.m_axis_tlast    = r_m_last;
  assign bus.m_axis_tid      = r_m_tid;
  assign bus.m_re_axis_tdata = r_m_re;
  assign bus.m_im_axis_tdata = r_m_im;
  assign err_short_out       = r_err_short;
  assign err_long_out        = r_err_long;
  assign frame_cnt_out       = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_arbiter
// Directed bench: queue-fed sources per channel, an output capture queue and
// hand-derived frame contents (CP stripped, pad zeros, tid, tlast position).
// ---------------------------------------------------------------------------
module tb_fft_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_s, err_l;
  logic [15:0] fcnt;
  logic        rnd_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [33:0] out_q[$];

  fft_frame_arbiter_if #(.WIDTH(16)) bus();

  fft_frame_arbiter #(.FFT_LEN(64), .CP_LEN(16), .WIDTH(16)) u_dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .bus           (bus),
    .err_clr_in    (err_clr),
    .err_short_out (err_s),
    .err_long_out  (err_l),
    .frame_cnt_out (fcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] eb(input logic tid, input logic last, input logic [15:0] v);
    logic [15:0] nv;
    nv = -v;
    return {tid, last, v, nv};
  endfunction

  // Symbol of n samples: re = base+k, im = -(base+k), tlast at k == last_at
  task automatic push_sym(input int ch, input int n, input int base, input int last_at);
    for (int k = 0; k < n; k++) begin
      logic [15:0] v, nv;
      v  = 16'(base + k);
      nv = -v;
      if (ch == 0) q0.push_back({k == last_at, v, nv});
      else         q1.push_back({k == last_at, v, nv});
    end
  endtask

  // Frame of 64 beats: nreal samples base+16.. then zeros, tlast on beat 63
  task automatic chk_frame(input int start, input logic tid, input int base, input int nreal);
    for (int i = 0; i < 64; i++) begin
      logic [15:0] v;
      logic [33:0] obs;
      v   = (i < nreal) ? 16'(base + 16 + i) : 16'd0;
      obs = (start + i < out_q.size()) ? out_q[start + i] : '1;
      chk($sformatf("f%0d_beat%0d", start / 64, i), obs, eb(tid, i == 63, v));
    end
  endtask

  task automatic wait_beats(input int n, input string tag);
    int cyc = 0;
    while (out_q.size() < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    chk(tag, out_q.size(), n);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    out_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Channel sources: pop on a handshake seen at the previous negedge
  initial begin : drv0
    logic fire;
    bus.s0_axis_tvalid = 1'b0; bus.s0_axis_tlast = 1'b0;
    bus.s0_re_axis_tdata = '0; bus.s0_im_axis_tdata = '0;
    forever begin
      @(negedge clk);
      fire = bus.s0_axis_tvalid && bus.s0_axis_tready;
      @(posedge clk); #1;
      if (fire && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) {bus.s0_axis_tlast, bus.s0_re_axis_tdata, bus.s0_im_axis_tdata} = q0[0];
      bus.s0_axis_tvalid = (q0.size() > 0);
    end
  end

  initial begin : drv1
    logic fire;
    bus.s1_axis_tvalid = 1'b0; bus.s1_axis_tlast = 1'b0;
    bus.s1_re_axis_tdata = '0; bus.s1_im_axis_tdata = '0;
    forever begin
      @(negedge clk);
      fire = bus.s1_axis_tvalid && bus.s1_axis_tready;
      @(posedge clk); #1;
      if (fire && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) {bus.s1_axis_tlast, bus.s1_re_axis_tdata, bus.s1_im_axis_tdata} = q1[0];
      bus.s1_axis_tvalid = (q1.size() > 0);
    end
  end

  initial begin : sink_rdy
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.m_axis_tready = rnd_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Output capture plus hold-while-stalled checks
  initial begin : mon
    logic        prev_stall;
    logic [33:0] held, cur;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {bus.m_axis_tid, bus.m_axis_tlast, bus.m_re_axis_tdata, bus.m_im_axis_tdata};
        if (prev_stall) begin
          chk("hold_vld", bus.m_axis_tvalid, 1'b1);
          chk("hold_data", cur, held);
        end
        if (bus.m_axis_tvalid && !bus.m_axis_tready && !bus.m_axis_tlast)
          chk("s0_rdy_stall", bus.s0_axis_tready, 1'b0);
        if (bus.m_axis_tvalid && bus.m_axis_tready) out_q.push_back(cur);
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        held = cur;
      end
    end
  end

  initial begin : main
    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_m_vld", bus.m_axis_tvalid, 1'b0);
    chk("rst_s0_rdy", bus.s0_axis_tready, 1'b0);
    chk("rst_s1_rdy", bus.s1_axis_tready, 1'b0);
    chk("rst_fcnt", fcnt, 16'd0);
    chk("rst_errs", {err_s, err_l}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ch0 symbol
    push_sym(0, 80, 0, 79);
    wait_beats(64, "t1_nbeats");
    chk_frame(0, 1'b0, 0, 64);
    chk("t1_fcnt", fcnt, 16'd1);
    chk("t1_errs", {err_s, err_l}, 2'b00);

    // Both channels saturated, 4 symbols each: strict alternation from ch0
    do_reset();
    for (int s = 0; s < 4; s++) begin
      push_sym(0, 80, 2000 + 100 * s, 79);
      push_sym(1, 80, 3000 + 100 * s, 79);
    end
    wait_beats(512, "t2_nbeats");
    for (int f = 0; f < 8; f++)
      chk_frame(f * 64, f[0], (f[0] ? 3000 : 2000) + (f / 2) * 100, 64);
    chk("t2_fcnt", fcnt, 16'd8);

    // Short ch1 symbol: tlast at sample 50
    out_q.delete();
    push_sym(1, 51, 0, 50);
    wait_beats(64, "t3_nbeats");
    chk_frame(0, 1'b1, 0, 35);
    chk("t3_errs", {err_s, err_l}, 2'b10);
    chk("t3_fcnt", fcnt, 16'd9);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("t3_clr", err_s, 1'b0);

    // Long ch0 symbol (90 samples) then a normal one
    out_q.delete();
    push_sym(0, 90, 4000, 89);
    push_sym(0, 80, 5000, 79);
    wait_beats(128, "t4_nbeats");
    chk_frame(0, 1'b0, 4000, 64);
    chk_frame(64, 1'b0, 5000, 64);
    chk("t4_errs", {err_s, err_l}, 2'b01);
    chk("t4_fcnt", fcnt, 16'd11);

    // Random backpressure, both channels; last winner was ch0 so ch1 goes first
    out_q.delete();
    rnd_rdy = 1'b1;
    push_sym(0, 80, 6000, 79);
    push_sym(1, 80, 7000, 79);
    wait_beats(128, "t5_nbeats");
    rnd_rdy = 1'b0;
    chk_frame(0, 1'b1, 7000, 64);
    chk_frame(64, 1'b0, 6000, 64);
    chk("t5_fcnt", fcnt, 16'd13);

    // Reset at output beat 20, asynchronous clear, then fresh arbitration
    out_q.delete();
    push_sym(0, 80, 8000, 79);
    begin
      int cyc = 0;
      while (out_q.size() < 20 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("t6_reach20", out_q.size() >= 20, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_m_vld", bus.m_axis_tvalid, 1'b0);
    chk("t6_m_last", bus.m_axis_tlast, 1'b0);
    chk("t6_m_data", {bus.m_axis_tid, bus.m_re_axis_tdata, bus.m_im_axis_tdata}, 33'd0);
    chk("t6_s0_rdy", bus.s0_axis_tready, 1'b0);
    chk("t6_fcnt", fcnt, 16'd0);
    chk("t6_errs", {err_s, err_l}, 2'b00);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    out_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_sym(1, 80, 9500, 79);
    push_sym(0, 80, 9000, 79);
    wait_beats(128, "t6_nbeats");
    chk_frame(0, 1'b0, 9000, 64);
    chk_frame(64, 1'b1, 9500, 64);
    chk("t6_fcnt_after", fcnt, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares one 64-point FFT wrapper between two antenna sample streams.
- Each input carries OFDM symbols of CP_LEN+FFT_LEN samples, with tlast on the final sample of each symbol.
- Grants one channel per whole symbol, round-robin, and strips the cyclic prefix.
- Emits exactly FFT_LEN samples per frame, with tlast and a channel id, to the FFT wrapper's AXIS sample port.
- Detects malformed symbols and repairs them: zero-pads short symbols, drains long ones.

Parameters:
- FFT_LEN, 64, samples forwarded per frame (power of 2, ≥4).
- CP_LEN, 16, leading samples discarded per symbol (≥1).
- WIDTH, 16, signed sample component width.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset; asynchronous assert, active-low.
- s0_axis_tvalid, s0_axis_tlast  in  1 each  channel 0 handshake/last.
- s0_re_axis_tdata, s0_im_axis_tdata  in  WIDTH each  channel 0 sample.
- s0_axis_tready  out  1  channel 0 ready.
- s1_axis_tvalid, s1_axis_tlast, s1_re_axis_tdata, s1_im_axis_tdata, s1_axis_tready  same as channel 0, for channel 1.
- m_axis_tvalid, m_axis_tlast  out  1 each  to FFT.
- m_re_axis_tdata, m_im_axis_tdata  out  WIDTH each  to FFT.
- m_axis_tid  out  1  channel of current frame.
- m_axis_tready  in  1  from FFT.
- err_clr_in  in  1  clears sticky error flags.
- err_short_out, err_long_out  out  1 each  sticky error flags.
- frame_cnt_out  out  16  frames emitted, wraps at 0xFFFF→0.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - All outputs 0; state IDLE; last_grant=1, so ch0 wins first.
  - Counters and error flags cleared.
  - Reset mid-frame abandons the frame. No tlast is emitted.
- FSM states: IDLE, CP, PASS, PAD, DRAIN. Counter idx counts samples accepted or emitted in the current state.
- IDLE:
  - Both s*_axis_tready = 0.
  - If exactly one tvalid is high, grant that channel.
  - If both are high, grant the channel ≠ last_grant.
  - On grant: register grant and last_grant, set idx=0, go to CP. Takes 1 cycle; no sample is consumed in IDLE.
- CP:
  - Granted tready = 1; the other = 0.
  - Accept and discard samples.
  - After CP_LEN accepts, go to PASS with idx=0.
  - If tlast is accepted in CP: set err_short, go to PAD with idx=0.
- PASS:
  - Granted tready = !m_axis_tvalid || m_axis_tready. The output is a single register stage, so latency is 1 cycle.
  - Each accepted sample is loaded to the m_* registers, with tid=grant and tlast=(idx==FFT_LEN-1).
  - At idx==FFT_LEN-1:
    - If input tlast is high, go to IDLE.
    - Otherwise set err_long and go to DRAIN.
  - If input tlast is accepted at idx<FFT_LEN-1: set err_short, go to PAD at idx+1.
- PAD:
  - Inputs not ready.
  - Emit zero samples, holding tid, until FFT_LEN total samples have been emitted. The final one carries tlast. Then go to IDLE.
- DRAIN:
  - Granted tready = 1; discard samples until tlast is accepted, then go to IDLE.
  - No output.
- Output handshake:
  - m_* is held stable while m_axis_tvalid && !m_axis_tready.
  - m_axis_tvalid drops after the transfer if no new load occurs.
  - Combinational path m_axis_tready → s*_axis_tready is permitted.
- frame_cnt_out increments on each output beat with tlast.
- Error flags:
  - err_* are sticky.
  - err_clr_in clears them. If a set and a clear occur in the same cycle, set wins.
- The ungranted channel is never ready. Its stream stalls upstream and is never dropped.
- IDLE→grant turnaround is 1 cycle minimum, so a full symbol occupies ≥ CP_LEN+FFT_LEN+1 cycles.

Test Plan:
- Single ch0 symbol, samples re=k, im=-k for k=0..79, tlast at k=79, m_axis_tready=1:
  - Outputs re=16..79, tlast on re=79, tid=0.
  - frame_cnt_out=1; no errors.
- Both channels continuously valid, 4 symbols each:
  - Output tid sequence 0,1,0,1,0,1,0,1.
  - Each frame is exactly 64 beats.
- ch1 symbol with tlast at sample 50:
  - 35 real samples (16..50), then 29 zeros, tlast on beat 64.
  - err_short_out=1; err_clr_in pulse clears it.
- ch0 symbol of 90 samples, tlast at 89:
  - 64 beats emitted (16..79).
  - Samples 80..89 consumed silently; err_long_out=1; next symbol is correctly framed.
- m_axis_tready random 30% duty during PASS:
  - No sample lost or duplicated.
  - m_* stable while stalled; s0_axis_tready low whenever the output is stalled.
- rst_n_in pulsed low at output beat 20:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, the next symbol is granted to ch0 and frames correctly.
